clk_div_multi: RTL

- Multi-channel programmable clock/tick divider; replaces the fixed single-ratio scan-clock divider.
- Each channel derives a divided-clock enable square wave (clk_out) and a one-cycle tick from the system clock.
- The divide ratio is runtime-writable per channel, with glitch-free changeover at period boundaries.
- Feeds display-scan, key-debounce and blink timing logic.

---
 rtl/clk_div_pkg.sv | 9 +
 rtl/clk_div_ch.sv | 68 ++++++
 rtl/clk_div_multi.sv | 44 ++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the multi-channel clock/tick divider
package clk_div_pkg;
  localparam int MIN_DIV = 2;
  localparam int CNT_W_DEF = 32;
  localparam int DEFAULT_DIV_DEF = 50000;
  function automatic logic [31:0] ceil_half(input logic [31:0] n);
    return (n >> 1) + {31'b0, n[0]};
  endfunction
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with shadowed divide ratio; CLK_DIV_SYNC_EN adds sync_clr
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync_clr,
`endif
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             clk_out
);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  logic [CNT_W-1:0] cnt, div_act, div_shd, h;
  logic pend, wrap, half;
  assign h = CNT_W'(ceil_half(32'(div_act)));
  assign wrap = cnt == div_act - CNT_W'(1);
  assign half = cnt == h - CNT_W'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      div_act <= RST_DIV;
      div_shd <= RST_DIV;
      pend <= 1'b0;
      tick <= 1'b0;
      clk_out <= 1'b0;
    end else begin
`ifdef CLK_DIV_SYNC_EN
      if (sync_clr) begin
        cnt <= '0;
        tick <= 1'b0;
        clk_out <= 1'b0;
        div_act <= pend ? div_shd : div_act;
        div_shd <= wr ? wr_div : div_shd;
        pend <= wr;
      end else
`endif
      if (!en) begin
        cnt <= '0;
        tick <= 1'b0;
        clk_out <= 1'b0;
        if (wr) begin
          div_act <= wr_div;
          div_shd <= wr_div;
          pend <= 1'b0;
        end
      end else begin
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
        tick <= wrap;
        clk_out <= wrap | (clk_out & ~half);
        // a write landing on the wrap edge takes effect for the very next period
        if (wrap) begin
          div_act <= wr ? wr_div : (pend ? div_shd : div_act);
          pend <= 1'b0;
        end else begin
          pend <= pend | wr;
        end
        if (wr) div_shd <= wr_div;
      end
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock/tick divider with write decode
// CLK_DIV_SYNC_EN adds the sync_clr input that phase-aligns all channels
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync_clr,
`endif
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic              wr_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);
  logic wr_ok;
  assign wr_ok = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH)) && (wr_div >= CNT_W'(MIN_DIV));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err <= 1'b0;
    else wr_err <= wr_en & ~wr_ok;
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk(clk),
      .rst(rst),
      .en(en[c]),
`ifdef CLK_DIV_SYNC_EN
      .sync_clr(sync_clr),
`endif
      .wr(wr_ok && wr_ch == CH_W'(c)),
      .wr_div(wr_div),
      .tick(tick[c]),
      .clk_out(clk_out[c])
    );
  end
endmodule
